// File: rtl/stim_pkg.sv
// Shared types and constants for the divided-clock stimulus generator.
// LFSR polynomial, default seed and the run-control state encoding.
package stim_pkg;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } stim_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR with synchronous load and step enable.
// A zero seed would lock up the register, so it is swapped for the default.
module lfsr16
    import stim_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic        lsb
);

    logic [15:0] state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            state <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

    assign lsb = state[0];

endmodule

// File: rtl/div_clk_stim_gen.sv
// Divided-clock and pseudo-random data stimulus source for derived-clock tests.
// Every output is a flop; the divider and run FSM live in one sequential block.
module div_clk_stim_gen
    import stim_pkg::*;
#(
    parameter int DIVW       = 4,
    parameter int RUN_CYCLES = 100,
    parameter int CYCW       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DIVW-1:0] div_ratio,
    input  logic [15:0]     seed,
    output logic            clk_div,
    output logic            clk_div_rise,
    output logic            data_q,
    output logic [CYCW-1:0] cyc,
    output logic            busy,
    output logic            done
);

    localparam logic [CYCW-1:0] CYC_LAST = CYCW'(RUN_CYCLES - 1);

    stim_state_e     state;
    logic [DIVW-1:0] n_lat;
    logic [DIVW-1:0] hp_cnt;
    logic            lfsr_lsb;
    logic            accept;
    logic            stepping;
    logic            hp_wrap;

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign stepping = (state == RUN) || (state == DRAIN);
    assign hp_wrap  = (hp_cnt == n_lat - 1'b1);

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .seed (seed),
        .step (stepping),
        .lsb  (lfsr_lsb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            clk_div      <= 1'b0;
            clk_div_rise <= 1'b0;
            data_q       <= 1'b0;
            hp_cnt       <= '0;
            n_lat        <= DIVW'(1);
            cyc          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            data_q       <= lfsr_lsb;
            clk_div_rise <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    clk_div <= 1'b0;
                    hp_cnt  <= '0;
                    if (start) begin
                        n_lat <= (div_ratio == '0) ? DIVW'(1) : div_ratio;
                        cyc   <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (hp_wrap) begin
                        hp_cnt       <= '0;
                        clk_div      <= ~clk_div;
                        clk_div_rise <= ~clk_div;
                    end else begin
                        hp_cnt <= hp_cnt + 1'b1;
                    end
                    if (cyc == CYC_LAST) begin
                        state <= DRAIN;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DRAIN: begin
                    // Only a pending high phase may finish; never start a new one.
                    if (!clk_div) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        hp_cnt <= '0;
                    end else if (hp_wrap) begin
                        hp_cnt  <= '0;
                        clk_div <= 1'b0;
                    end else begin
                        hp_cnt <= hp_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_clk_stim_gen.sv
// Randomized self-checking bench for div_clk_stim_gen against a closed-form model.
// Expected outputs are derived from the elapsed cycle count since the start edge.
module tb_div_clk_stim_gen;

    localparam int RC = 100;

    typedef struct packed {
        logic        clk_div;
        logic        rise;
        logic        data_q;
        logic [31:0] cyc;
        logic        busy;
        logic        done;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  div_ratio;
    logic [15:0] seed;
    logic        clk_div;
    logic        clk_div_rise;
    logic        data_q;
    logic [31:0] cyc;
    logic        busy;
    logic        done;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] frozen;

    div_clk_stim_gen #(.DIVW(4), .RUN_CYCLES(RC), .CYCW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .div_ratio    (div_ratio),
        .seed         (seed),
        .clk_div      (clk_div),
        .clk_div_rise (clk_div_rise),
        .data_q       (data_q),
        .cyc          (cyc),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lstep(input logic [15:0] l, input int m);
        logic [15:0] v;
        v = l;
        for (int i = 0; i < m; i++) v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
        return v;
    endfunction

    // First elapsed count at or after RC where the ideal square wave is low.
    function automatic int drain_end(input int n);
        int t;
        t = RC;
        while (((t / n) % 2) != 0) t++;
        return t;
    endfunction

    function automatic logic ideal(input int t, input int n, input int t0);
        return (t >= 0 && t <= t0) ? (((t / n) % 2) == 1) : 1'b0;
    endfunction

    // t = clk edges elapsed since the start edge (t=0 is just after it).
    function automatic obs_t model(input int t, input int d, input logic [15:0] s,
                                   input logic [15:0] prev);
        obs_t        e;
        int          n;
        int          t0;
        int          m;
        logic [15:0] sv;
        logic [15:0] l;
        n  = (d == 0) ? 1 : d;
        t0 = drain_end(n);
        sv = (s == 16'h0000) ? 16'hACE1 : s;
        e.clk_div = ideal(t, n, t0);
        e.rise    = (t >= 1) && ideal(t, n, t0) && !ideal(t - 1, n, t0);
        if (t == 0) begin
            e.data_q = prev[0];
        end else begin
            m = (t - 1 < t0 + 1) ? t - 1 : t0 + 1;
            l = lstep(sv, m);
            e.data_q = l[0];
        end
        e.cyc  = (t < RC - 1) ? 32'(t) : 32'(RC - 1);
        e.busy = (t <= t0);
        e.done = (t > t0);
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o = '{clk_div, clk_div_rise, data_q, cyc, busy, done};
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] d, input logic [15:0] s);
        start     = 1'b1;
        div_ratio = d;
        seed      = s;
        tick();
        start     = 1'b0;
        div_ratio = 4'($urandom);
        seed      = 16'($urandom);
    endtask

    task automatic test_reset();
        obs_t o;
        rst   = 1'b1;
        start = 1'b1;
        div_ratio = 4'd3;
        seed  = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            o = observe();
            checks++;
            if (o !== obs_t'(0)) begin
                errors++;
                $display("FAIL reset cyc%0d got %h want %h", i, o, obs_t'(0));
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || clk_div !== 1'b0 || data_q !== 1'b1) begin
            errors++;
            $display("FAIL reset_release busy=%b clk_div=%b data_q=%b want 0 0 1",
                     busy, clk_div, data_q);
        end
        frozen = 16'hACE1;
    endtask

    task automatic test_div1();
        obs_t e;
        obs_t o;
        int   t0;
        t0 = drain_end(1);
        do_start(4'd1, 16'h0001);
        for (int t = 0; t <= t0 + 3; t++) begin
            e = model(t, 1, 16'h0001, frozen);
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL div1 t=%0d got %h want %h", t, o, e);
            end
            tick();
        end
        frozen = lstep(16'h0001, t0 + 1);
    endtask

    task automatic test_div3();
        obs_t e;
        obs_t o;
        int   t0;
        int   rises;
        t0    = drain_end(3);
        rises = 0;
        do_start(4'd3, 16'hBEEF);
        for (int t = 0; t <= t0 + 3; t++) begin
            e = model(t, 3, 16'hBEEF, frozen);
            o = observe();
            if (clk_div_rise === 1'b1) rises++;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL div3 t=%0d got %h want %h", t, o, e);
            end
            tick();
        end
        checks++;
        if (rises != (t0 + 3) / 6) begin
            errors++;
            $display("FAIL div3_rises got %0d want %0d", rises, (t0 + 3) / 6);
        end
        frozen = lstep(16'hBEEF, t0 + 1);
    endtask

    task automatic test_div0_seed0();
        obs_t e;
        obs_t o;
        int   t0;
        t0 = drain_end(1);
        do_start(4'd0, 16'h0000);
        for (int t = 0; t <= t0 + 3; t++) begin
            e = model(t, 1, 16'hACE1, frozen);
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL div0_seed0 t=%0d got %h want %h", t, o, e);
            end
            tick();
        end
        frozen = lstep(16'hACE1, t0 + 1);
    endtask

    task automatic test_run_done();
        obs_t e;
        obs_t o;
        int   t0;
        t0 = drain_end(2);
        do_start(4'd2, 16'h5A5A);
        for (int t = 0; t <= t0 + 12; t++) begin
            e = model(t, 2, 16'h5A5A, frozen);
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL run_done t=%0d got %h want %h", t, o, e);
            end
            tick();
        end
        frozen = lstep(16'h5A5A, t0 + 1);
        do_start(4'd2, 16'h0F0F);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || cyc !== 32'd0) begin
            errors++;
            $display("FAIL restart done=%b busy=%b cyc=%0d want 0 1 0", done, busy, cyc);
        end
        for (int t = 1; t <= t0 + 2; t++) tick();
        frozen = lstep(16'h0F0F, t0 + 1);
    endtask

    task automatic test_back_to_back();
        obs_t        e;
        obs_t        o;
        int          t0;
        logic [3:0]  d;
        logic [15:0] s;
        for (int r = 0; r < 8; r++) begin
            d  = 4'($urandom_range(0, 15));
            s  = (r == 3) ? 16'h0000 : 16'($urandom);
            t0 = drain_end((d == 0) ? 1 : int'(d));
            do_start(d, s);
            for (int t = 0; t <= t0 + 2; t++) begin
                e = model(t, int'(d), s, frozen);
                o = observe();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL b2b run%0d div=%0d t=%0d got %h want %h", r, d, t, o, e);
                end
                // Stray starts while busy must be ignored.
                if (t < t0 && $urandom_range(0, 7) == 0) start = 1'b1;
                tick();
                start = 1'b0;
            end
            frozen = lstep((s == 16'h0000) ? 16'hACE1 : s, t0 + 1);
        end
    endtask

    task automatic test_mid_run_reset();
        int   waited;
        obs_t o;
        do_start(4'd4, 16'h1357);
        waited = 0;
        while (clk_div !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (clk_div !== 1'b1) begin
            errors++;
            $display("FAIL midrst_wait clk_div=%b want 1 within 20 cycles", clk_div);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        o = observe();
        checks++;
        if (o !== obs_t'(0)) begin
            errors++;
            $display("FAIL midrst got %h want %h", o, obs_t'(0));
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || clk_div !== 1'b0 || done !== 1'b0 || data_q !== 1'b1) begin
                errors++;
                $display("FAIL midrst_idle i=%0d busy=%b clk_div=%b done=%b data_q=%b want 0 0 0 1",
                         i, busy, clk_div, done, data_q);
            end
        end
        frozen = 16'hACE1;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        div_ratio = '0;
        seed      = '0;
        frozen    = 16'hACE1;
        test_reset();
        test_div1();
        test_div3();
        test_div0_seed0();
        test_run_done();
        test_back_to_back();
        test_mid_run_reset();
        test_div1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
